// File: rtl/register_file_2w.sv
// DEPTH x DATA_W register file: two combinational read ports, two synchronous write
// ports (port 3 wins collisions), optional hardwired zero register and write-first bypass.
module register_file_2w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A4,
  input  logic [DATA_W-1:0] WD4,
  input  logic              WE4
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam bit              ZERO_EN   = (ZERO_REG != 0);
  localparam bit              BYPASS_EN = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              wr3_s;
  logic              wr4_s;
  logic              byp_s;

  // Zero-register reads are forced to 0 ahead of any forwarding.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] addr,
    input logic              byp,
    input logic              wr3,
    input logic [ADDR_W-1:0] a3,
    input logic [DATA_W-1:0] wd3,
    input logic              wr4,
    input logic [ADDR_W-1:0] a4,
    input logic [DATA_W-1:0] wd4,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] res;
    if (ZERO_EN && (addr == ADDR_ZERO)) begin
      res = '0;
    end else if (byp && wr3 && (a3 == addr)) begin
      res = wd3;
    end else if (byp && wr4 && (a4 == addr)) begin
      res = wd4;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Effective write strobes: zero-register suppression and port-3 collision priority.
  always_comb begin
    wr3_s = WE3 && !(ZERO_EN && (A3 == ADDR_ZERO));
    wr4_s = WE4 && !(ZERO_EN && (A4 == ADDR_ZERO)) && !(wr3_s && (A3 == A4));
    byp_s = BYPASS_EN && rst_n;
  end

  // Next-state of every storage word.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr3_s && (A3 == ADDR_W'(i))) begin
        regs_d[i] = WD3;
      end else if (wr4_s && (A4 == ADDR_W'(i))) begin
        regs_d[i] = WD4;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Storage array with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    RD1 = read_mux(A1, byp_s, wr3_s, A3, WD3, wr4_s, A4, WD4, regs_q[A1]);
    RD2 = read_mux(A2, byp_s, wr3_s, A3, WD3, wr4_s, A4, WD4, regs_q[A2]);
  end

endmodule

// File: tb/tb_register_file_2w.sv
// Bench for register_file_2w: default, no-zero/no-bypass and narrow (16x8) instances
// share stimulus and are compared against an array-based reference model.
module tb_register_file_2w;

  logic        clk;
  logic        rst_n;
  logic [4:0]  a1, a2, a3, a4;
  logic [31:0] wd3, wd4;
  logic        we3, we4;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic [15:0] rd1_c, rd2_c;

  int n_cmp = 0;
  int n_err = 0;

  // Model storage per configuration: 0 default, 1 ZERO_REG=0/BYPASS=0, 2 16-bit x 8
  logic [31:0] mdl [3][32];

  typedef struct {
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we4;
    logic [4:0]  a4;
    logic [31:0] wd4;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] ea1;
    logic [31:0] ea2;
    logic [31:0] eb1;
    logic [31:0] eb2;
  } vec_t;

  vec_t tbl [12];

  register_file_2w u_dut (
    .clk(clk), .rst_n(rst_n), .A1(a1), .A2(a2), .RD1(rd1_a), .RD2(rd2_a),
    .A3(a3), .WD3(wd3), .WE3(we3), .A4(a4), .WD4(wd4), .WE4(we4)
  );

  register_file_2w #(.ZERO_REG(0), .BYPASS(0)) u_alt (
    .clk(clk), .rst_n(rst_n), .A1(a1), .A2(a2), .RD1(rd1_b), .RD2(rd2_b),
    .A3(a3), .WD3(wd3), .WE3(we3), .A4(a4), .WD4(wd4), .WE4(we4)
  );

  register_file_2w #(.DATA_W(16), .ADDR_W(3)) u_small (
    .clk(clk), .rst_n(rst_n), .A1(a1[2:0]), .A2(a2[2:0]), .RD1(rd1_c), .RD2(rd2_c),
    .A3(a3[2:0]), .WD3(wd3[15:0]), .WE3(we3), .A4(a4[2:0]), .WD4(wd4[15:0]), .WE4(we4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit cfg_zero(int c);
    return (c != 1);
  endfunction

  function automatic bit cfg_byp(int c);
    return (c != 1);
  endfunction

  function automatic logic [4:0] cfg_amask(int c);
    return (c == 2) ? 5'd7 : 5'd31;
  endfunction

  function automatic logic [31:0] cfg_dmask(int c);
    return (c == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Expected read value: zero register, then write-first forwarding, then storage.
  function automatic logic [31:0] exp_rd(int c, logic [4:0] a);
    logic [4:0]  m  = cfg_amask(c);
    logic [31:0] dm = cfg_dmask(c);
    logic [4:0]  aa = a & m;
    if (cfg_zero(c) && aa == 5'd0) return 32'd0;
    if (cfg_byp(c) && rst_n === 1'b1) begin
      if (we3 === 1'b1 && (a3 & m) == aa) return wd3 & dm;
      if (we4 === 1'b1 && (a4 & m) == aa) return wd4 & dm;
    end
    return mdl[c][aa];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s def.RD1", tag), rd1_a, exp_rd(0, a1));
    check($sformatf("%s def.RD2", tag), rd2_a, exp_rd(0, a2));
    check($sformatf("%s alt.RD1", tag), rd1_b, exp_rd(1, a1));
    check($sformatf("%s alt.RD2", tag), rd2_b, exp_rd(1, a2));
    check($sformatf("%s small.RD1", tag), {16'h0000, rd1_c}, exp_rd(2, a1));
    check($sformatf("%s small.RD2", tag), {16'h0000, rd2_c}, exp_rd(2, a2));
  endtask

  task automatic clear_model();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 32; i++) mdl[c][i] = 32'd0;
  endtask

  task automatic set_reset(input logic v);
    rst_n = v;
    if (!v) clear_model();
  endtask

  // Port 4 applied first so port 3 overwrites it on a collision.
  task automatic commit();
    if (rst_n === 1'b1) begin
      for (int c = 0; c < 3; c++) begin
        if (we4 === 1'b1 && !(cfg_zero(c) && (a4 & cfg_amask(c)) == 5'd0))
          mdl[c][a4 & cfg_amask(c)] = wd4 & cfg_dmask(c);
        if (we3 === 1'b1 && !(cfg_zero(c) && (a3 & cfg_amask(c)) == 5'd0))
          mdl[c][a3 & cfg_amask(c)] = wd3 & cfg_dmask(c);
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic drive(input logic w3, input logic [4:0] ad3, input logic [31:0] d3,
                       input logic w4, input logic [4:0] ad4, input logic [31:0] d4,
                       input logic [4:0] r1, input logic [4:0] r2);
    we3 = w3; a3 = ad3; wd3 = d3;
    we4 = w4; a4 = ad4; wd4 = d4;
    a1 = r1; a2 = r2;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 5'd2, 32'd12,     1'b1, 5'd5, 32'd15,     5'd2, 5'd5, 32'd12, 32'd15, 32'd0, 32'd0};
    tbl[1]  = '{1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,      5'd2, 5'd5, 32'd12, 32'd15, 32'd12, 32'd15};
    tbl[2]  = '{1'b1, 5'd7, 32'd17,     1'b1, 5'd7, 32'd99,     5'd7, 5'd7, 32'd17, 32'd17, 32'd0, 32'd0};
    tbl[3]  = '{1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,      5'd7, 5'd7, 32'd17, 32'd17, 32'd17, 32'd17};
    tbl[4]  = '{1'b1, 5'd0, 32'h1234,   1'b0, 5'd0, 32'd0,      5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    tbl[5]  = '{1'b0, 5'd0, 32'd0,      1'b1, 5'd0, 32'h1234,   5'd0, 5'd0, 32'd0, 32'd0, 32'h1234, 32'h1234};
    tbl[6]  = '{1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,      5'd0, 5'd2, 32'd0, 32'd12, 32'h1234, 32'd12};
    tbl[7]  = '{1'b1, 5'd3, 32'd4,      1'b0, 5'd0, 32'd0,      5'd3, 5'd3, 32'd4, 32'd4, 32'd0, 32'd0};
    tbl[8]  = '{1'b1, 5'd3, 32'd8,      1'b0, 5'd0, 32'd0,      5'd3, 5'd3, 32'd8, 32'd8, 32'd4, 32'd4};
    tbl[9]  = '{1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,      5'd3, 5'd5, 32'd8, 32'd15, 32'd8, 32'd15};
    tbl[10] = '{1'b1, 5'd6, 32'd66,     1'b1, 5'd5, 32'd77,     5'd5, 5'd6, 32'd77, 32'd66, 32'd15, 32'd0};
    tbl[11] = '{1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0,      5'd5, 5'd6, 32'd77, 32'd66, 32'd77, 32'd66};

    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd31);
    set_reset(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset def.RD1", rd1_a, 32'd0);
    check_all("reset");
    set_reset(1'b1);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].we3, tbl[i].a3, tbl[i].wd3, tbl[i].we4, tbl[i].a4, tbl[i].wd4, tbl[i].a1, tbl[i].a2);
      #1;
      check($sformatf("vec%0d def.RD1", i), rd1_a, tbl[i].ea1);
      check($sformatf("vec%0d def.RD2", i), rd2_a, tbl[i].ea2);
      check($sformatf("vec%0d alt.RD1", i), rd1_b, tbl[i].eb1);
      check($sformatf("vec%0d alt.RD2", i), rd2_b, tbl[i].eb2);
      check_all($sformatf("vec%0d", i));
      edge_step();
    end

    // Asynchronous reset between edges, then edges under reset must not write
    drive(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    #1;
    check_all("rst.wr");
    edge_step();
    we3 = 1'b0;
    #1;
    check("rst.before def.RD1", rd1_a, 32'hDEAD_BEEF);
    #2;
    set_reset(1'b0);
    #1;
    check("rst.async def.RD1", rd1_a, 32'd0);
    check_all("rst.async");
    drive(1'b1, 5'd9, 32'd5, 1'b1, 5'd4, 32'd6, 5'd9, 5'd4);
    #1;
    check("rst.nobyp def.RD1", rd1_a, 32'd0);
    check("rst.nobyp def.RD2", rd2_a, 32'd0);
    edge_step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd4);
    set_reset(1'b1);
    #1;
    check("rst.nowrite def.RD1", rd1_a, 32'd0);
    check("rst.nowrite def.RD2", rd2_a, 32'd0);
    check_all("rst.after");
    edge_step();

    // Unknown addresses with enables low must not disturb anything
    drive(1'b0, 5'bxxxxx, 32'hFFFF_FFFF, 1'b0, 5'bxxxxx, 32'hFFFF_FFFF, 5'd2, 5'd3);
    #1;
    check_all("xaddr.pre");
    edge_step();
    check_all("xaddr.post");

    // Sweep: i*3 to every address, alternating ports, then read all back
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0)
        drive(1'b1, 5'(i), 32'(i * 3), 1'b0, 5'd0, 32'd0, 5'(i), 5'(i));
      else
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(i * 3), 5'(i), 5'(i));
      #1;
      check_all($sformatf("sweep.wr%0d", i));
      edge_step();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i));
      #1;
      check($sformatf("sweep.rd%0d def.RD1", i), rd1_a, (i == 0) ? 32'd0 : 32'(i * 3));
      check($sformatf("sweep.rd%0d def.RD2", i), rd2_a, (i == 0) ? 32'd0 : 32'(i * 3));
      check_all($sformatf("sweep.rd%0d", i));
      edge_step();
    end

    // Randomised traffic with dense collisions and occasional resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 63) == 0) set_reset(1'b0);
      else if (rst_n == 1'b0) set_reset(1'b1);
      we3 = 1'($urandom);
      we4 = 1'($urandom);
      wd3 = $urandom;
      wd4 = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        a1 = 5'($urandom_range(0, 3)); a2 = 5'($urandom_range(0, 3));
        a3 = 5'($urandom_range(0, 3)); a4 = 5'($urandom_range(0, 3));
      end else begin
        a1 = 5'($urandom); a2 = 5'($urandom);
        a3 = 5'($urandom); a4 = 5'($urandom);
      end
      #1;
      check_all($sformatf("rand%0d", k));
      edge_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
